// File: rtl/three_phase_demod.sv
// Three-channel sinc^2 CIC decimator for the 1-bit sigma-delta phase bitstreams.
// One shared decimation counter keeps the A/B/C output samples time-aligned.
module three_phase_demod #(
  parameter int DEC_LOG2 = 6,
  parameter int OUT_BW   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     phaseA,
  input  logic                     phaseB,
  input  logic                     phaseC,
  output logic signed [OUT_BW-1:0] outA,
  output logic signed [OUT_BW-1:0] outB,
  output logic signed [OUT_BW-1:0] outC,
  output logic                     out_valid,
  output logic signed [OUT_BW+1:0] sum_abc
);

  localparam int ACC_BW = 2*DEC_LOG2+2;
  localparam int SHIFT  = OUT_BW-1-2*DEC_LOG2;
  localparam int SW     = ACC_BW+SHIFT;
  localparam logic signed [SW-1:0] S_MAX = SW'((64'sd1 <<< (OUT_BW-1)) - 64'sd1);
  localparam logic [DEC_LOG2-1:0]  CNT_LAST   = '1;
  localparam logic [1:0]           WARM_READY = 2'd2;

  logic [DEC_LOG2-1:0] cnt;
  logic [1:0]          warm;
  logic                dec_evt;

  logic [2:0]                     ph;
  logic [ACC_BW-1:0]              x  [3];
  logic [ACC_BW-1:0]              i1 [3];
  logic [ACC_BW-1:0]              i2 [3];
  logic [ACC_BW-1:0]              d1 [3];
  logic [ACC_BW-1:0]              d2 [3];
  logic signed [ACC_BW-1:0]       y  [3];
  logic signed [SW-1:0]           s  [3];
  logic signed [OUT_BW-1:0]       sat[3];
  logic signed [OUT_BW-1:0]       out_r[3];

  assign ph      = {phaseC, phaseB, phaseA};
  assign dec_evt = en && (cnt == CNT_LAST);

  // All CIC arithmetic wraps modulo 2**ACC_BW; the comb differences undo it.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      x[c]   = ph[c] ? ACC_BW'(1) : '1;
      y[c]   = signed'(i2[c] - d1[c] - d2[c]);
      s[c]   = SW'(y[c]);
      s[c]   = s[c] <<< SHIFT;
      // Only an all-ones window (y = R^2) can exceed positive full scale.
      sat[c] = (s[c] > S_MAX) ? OUT_BW'(S_MAX) : OUT_BW'(s[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      warm      <= '0;
      out_valid <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        i1[c]    <= '0;
        i2[c]    <= '0;
        d1[c]    <= '0;
        d2[c]    <= '0;
        out_r[c] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (en) begin
        cnt <= cnt + 1'b1;
        for (int c = 0; c < 3; c++) begin
          i1[c] <= i1[c] + x[c];
          i2[c] <= i2[c] + i1[c];
        end
        if (dec_evt) begin
          out_valid <= (warm == WARM_READY);
          if (warm != WARM_READY) warm <= warm + 1'b1;
          for (int c = 0; c < 3; c++) begin
            d1[c]    <= i2[c];
            d2[c]    <= i2[c] - d1[c];
            out_r[c] <= sat[c];
          end
        end
      end
    end
  end

  assign outA    = out_r[0];
  assign outB    = out_r[1];
  assign outC    = out_r[2];
  assign sum_abc = (OUT_BW+2)'(out_r[0]) + (OUT_BW+2)'(out_r[1]) + (OUT_BW+2)'(out_r[2]);

endmodule

// File: doc/three_phase_demod.md
Name: three_phase_demod

Overview:
- Recovers multi-bit samples from the three 1-bit sigma-delta phase bitstreams (A, B, C) produced by the three-phase generator.
- Each channel runs a 2nd-order CIC (sinc^2) decimator by R = 2**DEC_LOG2. All three channels share one decimation counter, so their output samples are time-aligned.
- Used on the measurement/loopback side to check amplitude, phase balance and frequency of the generated waveforms.

Parameters:
- DEC_LOG2, 6, log2 of the decimation ratio R (R = 64 by default).
- OUT_BW, 16, signed output sample width. Must satisfy OUT_BW-1 >= 2*DEC_LOG2.
- localparam ACC_BW = 2*DEC_LOG2+2, width of the integrator and comb registers.
- localparam SHIFT = OUT_BW-1-2*DEC_LOG2, left shift applied to the comb result.

Ports:
- clk  in  1  system clock; the same clock that drives the bitstream generator.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample enable. When low, all state holds and no output strobe is issued.
- phaseA, phaseB, phaseC  in  1 each  sigma-delta bitstreams. 1 means +1, 0 means -1.
- outA, outB, outC  out  OUT_BW each  signed decimated samples.
- out_valid  out  1  one-cycle strobe marking new outA/outB/outC.
- sum_abc  out  OUT_BW+2  signed outA+outB+outC, combinational from the registered outputs (phase-balance check).

Behaviour:
- Reset (asynchronous assert, clears on the next clk edge after release):
  - integrators, comb delays, dec counter and warm counter go to 0.
  - outA/B/C = 0, out_valid = 0, so sum_abc = 0.
- Input mapping per channel: x = phase ? +1 : -1, sign-extended to ACC_BW.
- Per clk with en=1, per channel:
  - i1 <= i1 + x
  - i2 <= i2 + i1, using the old i1.
  - All ACC_BW arithmetic wraps modulo 2**ACC_BW; no saturation inside the CIC. Wrap is correct by construction and must not be "fixed".
- Decimation counter cnt:
  - ranges 0..R-1 and increments on each en=1 cycle, wrapping R-1 -> 0.
  - A decimation event is a clk edge with en=1 and cnt==R-1.
- On a decimation event, per channel, using pre-edge values:
  - y = (i2 - d1) - d2
  - d2 <= i2 - d1
  - d1 <= i2
- Scaling and saturation:
  - s = y sign-extended, then <<< SHIFT.
  - If s > 2**(OUT_BW-1)-1, clamp to 2**(OUT_BW-1)-1. The only overflow case is an all-ones window, y = R^2.
  - The lower bound needs no clamp (y >= -R^2).
  - The result is registered into outX on the decimation event edge.
- Warm-up: a warm counter saturates at 2 and increments on each decimation event.
  - out_valid <= 1 on a decimation event when warm==2 (the pre-edge value); otherwise out_valid <= 0.
  - First valid strobe comes on the 3rd decimation event, i.e. the edge ending the 3R-th en cycle after reset.
  - outX still updates on the 1st and 2nd events (transient values), but no strobe is issued for them.
- Latency: out_valid is high for exactly one cycle, the cycle after the decimation event edge. outX holds its value until the next event.
- en=0: integrators, cnt, d1/d2 and warm all hold; out_valid <= 0.
  - en toggling does not lose or duplicate samples; only en=1 cycles count.
- Reset mid-operation: all state clears immediately (async), including a pending out_valid. The warm-up sequence restarts.
- Steady-state transfer: y = sum of x over a triangular window of length 2R-1 (peak weight R), so DC gain is R^2.
  - A bitstream with mean m in [-1,+1] yields outX = round-free m*2**(OUT_BW-1), clamped at +full scale.

Test Plan:
- Reset release, phaseA=1, phaseB=0, phaseC alternating 1/0, en=1 (DEC_LOG2=6, OUT_BW=16):
  - first out_valid on the edge ending cycle 192.
  - outA=32767 (clamped), outB=-32768, |outC| <= 512.
  - out_valid is then exactly 1 cycle high every 64 cycles.
- Periodic patterns, phaseA 1,1,1,0 and phaseB 1,0,0,0 (period 4), phaseC=0:
  - after warm-up outA=16384, outB=-16384, outC=-32768, sum_abc=-32768, all stable on every strobe.
- Generator loopback with omega set for a period of many R, three phases 120 degrees apart:
  - sum_abc stays within ±1% FS.
  - outA peak ≈ 2**(OUT_BW-3) ±2%; the saturating high-resolution path reaches full scale via R^2 scaling.
- en held low 100 cycles mid-run with the constant-1 input:
  - no out_valid during the gap.
  - strobe spacing counted in en=1 cycles stays 64.
  - outA unchanged (32767) across the gap.
- rst pulsed 1 cycle, asynchronously, in the cycle that out_valid would otherwise be high:
  - out_valid never asserts and outA/B/C read 0 while rst is high.
  - the next strobe comes 192 en-cycles after release.
- Long-run wrap check with a 24-cycle 1s / 8-cycle 0s pattern over >10^6 cycles:
  - outA = 16384 on every strobe.
  - no drift despite i1/i2 wrapping.
